// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM state encoding for reg_dump_reader.
// The CSUM state exists only when DUMP_CHECKSUM_EN is defined.
package reg_dump_reader_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3
`ifdef DUMP_CHECKSUM_EN
    ,
    ST_CSUM = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks an external register file from FIRST_REG to LAST_REG and streams each word out on a valid/ready port.
// Optional build macro DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
//
// state | meaning
// IDLE  | waiting for start_i; rd_addr_o parked at FIRST_REG
// READ  | rd_data_i for the current index captured into the hold register
// SEND  | hold register offered on the dump port until accepted
// CSUM  | checksum word offered (DUMP_CHECKSUM_EN builds only)
// DONE  | one-cycle done_o pulse, then back to IDLE
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  input  logic [REG_DATA_W-1:0] rd_data_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [REG_ADDR_W-1:0] dump_addr_o,
  output logic [REG_DATA_W-1:0] dump_data_o,
  output logic                  dump_last_o,
  output logic                  done_o
);

  localparam logic [REG_ADDR_W-1:0] FIRST_A = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] LAST_A  = REG_ADDR_W'(LAST_REG);

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   idx_q, idx_d;
  logic [REG_DATA_W-1:0]   hold_q, hold_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic [REG_ADDR_W-1:0]   addr_q, addr_d;
  logic [REG_DATA_W-1:0]   data_q, data_d;
`ifdef DUMP_CHECKSUM_EN
  logic [REG_DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_d   = FIRST_A;
          state_d = ST_READ;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_READ: begin
        hold_d  = rd_data_i;
        state_d = ST_SEND;
`ifdef DUMP_CHECKSUM_EN
        csum_d  = csum_q ^ rd_data_i;
`endif
      end
      ST_SEND: begin
        if (dump_ready_i) begin
          // Index stops at LAST_REG so LAST_REG=31 never wraps to 0.
          if (idx_q == LAST_A) begin
`ifdef DUMP_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + REG_ADDR_W'(1);
            state_d = ST_READ;
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (dump_ready_i) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        idx_d   = FIRST_A;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = FIRST_A;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops cleanly.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    addr_d  = idx_d;
    data_d  = hold_d;
`ifdef DUMP_CHECKSUM_EN
    valid_d = (state_d == ST_SEND) || (state_d == ST_CSUM);
    last_d  = (state_d == ST_CSUM);
    if (state_d == ST_CSUM) begin
      addr_d = '0;
      data_d = csum_d;
    end
`else
    valid_d = (state_d == ST_SEND);
    last_d  = (state_d == ST_SEND) && (idx_d == LAST_A);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= FIRST_A;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= FIRST_A;
      data_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy_o       = busy_q;
  assign rd_addr_o    = idx_q;
  assign dump_valid_o = valid_q;
  assign dump_addr_o  = addr_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = last_q;
  assign done_o       = done_q;

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, meaning the first register index dumped.
REQ-002 The block SHALL have parameter LAST_REG, default 31, meaning the last register index dumped; FIRST_REG <= LAST_REG <= 31 is required.
REQ-003 The block SHALL have the ports listed below; reset rst_n is asynchronous, active-low; clock clk_i.
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  request one full dump; sampled in IDLE only.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 rd_addr_o  output  5  read address driven to the register-file read port.
REQ-009 rd_data_i  input  32  combinational read data returned for rd_addr_o.
REQ-010 dump_valid_o  output  1  dump word available.
REQ-011 dump_ready_i  input  1  consumer accepts word when high with dump_valid_o.
REQ-012 dump_addr_o  output  5  register index of the current dump word.
REQ-013 dump_data_o  output  32  current dump word.
REQ-014 dump_last_o  output  1  marks the final word of the dump.
REQ-015 done_o  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 The FSM SHALL have states IDLE, READ, SEND, DONE, plus CSUM when DUMP_CHECKSUM_EN is defined.
REQ-017 IDLE with start_i=1 SHALL load the index counter with FIRST_REG and go to READ on the next edge.
REQ-018 READ SHALL drive rd_addr_o = index, capture rd_data_i into a 32-bit hold register, and go to SEND in one cycle.
REQ-019 SEND SHALL assert dump_valid_o, with dump_addr_o = index and dump_data_o = hold register, held stable until dump_ready_i=1.
REQ-020 On acceptance in SEND with index < LAST_REG, the counter SHALL increment and the FSM SHALL return to READ.
REQ-021 On acceptance with index == LAST_REG, the FSM SHALL go to DONE, or to CSUM when the checksum is enabled.
REQ-022 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-023 Throughput SHALL be one word per 2 cycles with dump_ready_i held high; the first dump_valid_o comes 2 cycles after the start_i edge.
REQ-024 Each word SHALL be a snapshot taken in its READ cycle; register writes during a dump affect only words not yet read.
REQ-025 start_i while busy_o=1 SHALL be ignored, with no restart and no queueing.
REQ-026 rd_addr_o SHALL equal the index counter in all states (FIRST_REG in IDLE).
REQ-027 dump_last_o SHALL be high only with dump_valid_o on the final word: index==LAST_REG without the checksum, the CSUM word with it.
REQ-028 The counter SHALL never wrap; LAST_REG=31 terminates without overflow to 0.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-dump, SHALL force IDLE, counter=FIRST_REG, hold=0, checksum=0.
REQ-030 During reset, the outputs SHALL be busy_o=0, dump_valid_o=0, dump_last_o=0, done_o=0, dump_data_o=0, dump_addr_o=FIRST_REG.
REQ-031 No partial dump SHALL resume after reset release; a new start_i is required.

Configuration
REQ-032 The macro DUMP_CHECKSUM_EN, when defined, SHALL add a 32-bit XOR accumulator, cleared on start and XORed with every captured word in READ.
REQ-033 With DUMP_CHECKSUM_EN defined, the CSUM state SHALL send one extra word: dump_addr_o=0, dump_data_o=accumulator, dump_last_o=1; on acceptance the FSM goes to DONE.
REQ-034 Without DUMP_CHECKSUM_EN, there SHALL be no accumulator or CSUM state, and the dump is exactly LAST_REG-FIRST_REG+1 words.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the REG_ADDR_W=5 and REG_DATA_W=32 constants, and the NUM_REGS=32 constant.
REQ-036 The block SHALL be a single module with no sub-modules; the register file is external, connected via rd_addr_o/rd_data_i.

Verification
REQ-037 Register file reset (reg 29=128, others 0), start_i pulse, ready=1 -> 32 words, addr 0..31, word 29=128, dump_last_o on addr 31, done_o 65 cycles after start.
REQ-038 Ready toggled 1/0 every cycle -> no word lost or duplicated, data/addr stable while valid && !ready.
REQ-039 start_i re-pulsed mid-dump -> ignored, a single dump completes, one done_o.
REQ-040 rst_n low while SEND at addr 10 -> immediate IDLE, valid=0, and a new start dumps from addr 0.
REQ-041 FIRST_REG=8, LAST_REG=8 -> exactly one word, addr 8, with last=1.
REQ-042 DUMP_CHECKSUM_EN with regs 1=0x0000FFFF, 2=0xFFFF0000, others 0 -> 33rd word 0xFFFFFFFF with last=1.
